// File: rtl/sfr_pkg.sv
// rtl/sfr_pkg.sv - shared state type, line levels and frame-length helper for serial_frame_rx
// No ports (package). Imported by serial_frame_rx and sfr_hold_reg.
package sfr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } sfr_state_t;

  // Line rests low between frames; a high sample in IDLE is a start bit.
  localparam logic IDLE_LEVEL = 1'b0;
  // A good stop bit is low, so an idle line directly after a frame is legal.
  localparam logic STOP_LEVEL = 1'b0;

  // Total cycles one frame occupies on the line: start + data + [parity] + stop.
  function automatic int frame_len(input int data_w, input bit parity_en);
    return data_w + 2 + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/sfr_hold_reg.sv
// rtl/sfr_hold_reg.sv - one-entry valid/ready holding register
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   load, load_data    write a new entry (caller guarantees !full or ready)
//   ready              consumer accepts the entry when valid && ready
//   data, valid        held entry and its valid flag
//   full               entry occupied (same as valid, for producer-side flow control)
module sfr_hold_reg
  import sfr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         full
);

  // A load in the same cycle as a drain replaces the entry, so valid stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign full = valid;

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - synchronous one-bit-per-clock serial frame receiver
// Optional feature macro: SFR_PARITY_EN (adds a PARITY state with even-parity check).
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   serial_in          serial line, idle low; frame = start(1), DATA_W data bits, [parity], stop(0)
//   m_data, m_valid    received word and valid flag, held until m_ready
//   m_ready            consumer ready
//   busy               frame in progress (state != IDLE)
//   frame_err          one-cycle pulse: stop bit was high
//   parity_err         one-cycle pulse: parity mismatch (constant 0 without SFR_PARITY_EN)
//   overrun            one-cycle pulse: good word dropped because holding register was full
module serial_frame_rx
  import sfr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

`ifdef SFR_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int FRAME_LEN = frame_len(DATA_W, PARITY_ON);
  localparam int CNT_W     = $clog2(FRAME_LEN);

  sfr_state_t        state;
  sfr_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              last_bit;
  logic              hold_full;
  logic              par_bad;
  logic              stop_ok;
  logic              word_good;
  logic              load;
  logic              frame_err_nxt;
  logic              overrun_nxt;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[DATA_W-2:0], b};
    else           return {b, cur[DATA_W-1:1]};
  endfunction

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (serial_in != IDLE_LEVEL) state_nxt = DATA;
`ifdef SFR_PARITY_EN
      DATA:   if (last_bit) state_nxt = PARITY;
      PARITY: state_nxt = STOP;
`else
      DATA:   if (last_bit) state_nxt = STOP;
      PARITY: state_nxt = IDLE;
`endif
      STOP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / decision logic; the stop-cycle decisions are registered below
  // so every status change appears the cycle after the stop bit.
  always_comb begin
    busy          = (state != IDLE);
    stop_ok       = (state == STOP) && (serial_in == STOP_LEVEL);
    frame_err_nxt = (state == STOP) && (serial_in != STOP_LEVEL);
    word_good     = stop_ok && !par_bad;
    load          = word_good && (!hold_full || m_ready);
    overrun_nxt   = word_good && hold_full && !m_ready;
  end

  // Shifter and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state == DATA) begin
      shreg <= shift_in(shreg, serial_in);
      cnt   <= cnt + 1'b1;
    end
  end

`ifdef SFR_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  par_bit <= 1'b0;
    else if (state == PARITY) par_bit <= serial_in;
  end

  // Even parity over data plus parity bit: any odd total is a mismatch.
  assign par_bad = ^{shreg, par_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= stop_ok && par_bad;
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_err_nxt;
      overrun   <= overrun_nxt;
    end
  end

  sfr_hold_reg #(
    .W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (shreg),
    .ready     (m_ready),
    .data      (m_data),
    .valid     (m_valid),
    .full      (hold_full)
  );

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx
module tb_serial_frame_rx;

  localparam int DATA_W = 8;
`ifdef SFR_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              serial_in;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              busy;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  int errors = 0;
  int checks = 0;
  int n_fe = 0, n_pe = 0, n_ov = 0, n_acc = 0, n_busy = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_word;

  always #5 clk = ~clk;

  serial_frame_rx #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // Scoreboard side: every accepted word is compared with the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)  n_fe++;
      if (parity_err) n_pe++;
      if (overrun)    n_ov++;
      if (busy)       n_busy++;
      if (m_valid && m_ready) begin
        n_acc++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_word got=%h expected=none", m_data);
        end else begin
          exp_word = exp_q.pop_front();
          if (m_data !== exp_word) begin
            errors++;
            $display("FAIL sb_word got=%h expected=%h", m_data, exp_word);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the edge that sampled the stop bit.
  task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop_b,
                            input logic bad_par, input bit ready_on_stop);
    logic par;
    par = (^w) ^ bad_par;
    send_bit(1'b1);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
    if (PAR_ON) send_bit(par);
    if (ready_on_stop) m_ready = 1'b1;
    send_bit(stop_b);
    serial_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serial_in = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d got busy=%b m_valid=%b expected 0 0", i, busy, m_valid);
      end
    end
    checks++;
    if (m_data !== '0 || frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h fe=%b pe=%b ov=%b expected all 0",
               m_data, frame_err, parity_err, overrun);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int b0, a0;
    m_ready = 1'b1;
    exp_q.push_back(8'hCC);
    b0 = n_busy;
    a0 = n_acc;
    send_frame(8'hCC, 1'b0, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hCC) begin
      errors++;
      $display("FAIL single_valid got valid=%b data=%h expected 1 cc", m_valid, m_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle got m_valid=%b expected 0", m_valid);
    end
    checks++;
    if (n_acc - a0 !== 1) begin
      errors++;
      $display("FAIL single_accepts got=%0d expected=1", n_acc - a0);
    end
    checks++;
    if (n_busy - b0 !== DATA_W + 1 + int'(PAR_ON)) begin
      errors++;
      $display("FAIL single_busy_len got=%0d expected=%0d", n_busy - b0, DATA_W + 1 + int'(PAR_ON));
    end
  endtask

  task automatic test_overrun();
    int ov0;
    m_ready = 1'b0;
    ov0 = n_ov;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'hA5) begin
      errors++;
      $display("FAIL overrun_pulse got ov=%b valid=%b data=%h expected 1 1 a5", overrun, m_valid, m_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b0 || n_ov - ov0 !== 1) begin
      errors++;
      $display("FAIL overrun_once got ov=%b count=%0d expected 0 1", overrun, n_ov - ov0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL overrun_drain got valid=%b pending=%0d expected 0 0", m_valid, exp_q.size());
    end
  endtask

  task automatic test_frame_err();
    int fe0;
    m_ready = 1'b1;
    fe0 = n_fe;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_pulse got fe=%b valid=%b busy=%b expected 1 0 0", frame_err, m_valid, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (frame_err !== 1'b0 || n_fe - fe0 !== 1) begin
      errors++;
      $display("FAIL frame_err_once got fe=%b count=%0d expected 0 1", frame_err, n_fe - fe0);
    end
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h01) begin
      errors++;
      $display("FAIL frame_err_recover got valid=%b data=%h expected 1 01", m_valid, m_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midframe();
    int fe0, pe0, ov0;
    m_ready = 1'b1;
    fe0 = n_fe;
    pe0 = n_pe;
    ov0 = n_ov;
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rst = 1'b1;
    serial_in = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busy got=%b expected=0", busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || n_fe != fe0 || n_pe != pe0 || n_ov != ov0) begin
      errors++;
      $display("FAIL midreset_quiet got busy=%b valid=%b fe+%0d pe+%0d ov+%0d expected all 0",
               busy, m_valid, n_fe - fe0, n_pe - pe0, n_ov - ov0);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hFF) begin
      errors++;
      $display("FAIL midreset_next got valid=%b data=%h expected 1 ff", m_valid, m_data);
    end
    @(posedge clk);
    #1;
  endtask

  // Holding register full but drained in the stop cycle: new word loads, no overrun.
  task automatic test_back_to_back();
    int ov0;
    m_ready = 1'b0;
    ov0 = n_ov;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h22 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load got valid=%b data=%h ov=%b expected 1 22 0", m_valid, m_data, overrun);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || n_ov != ov0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_drain got valid=%b ov_count=%0d pending=%0d expected 0 0 0",
               m_valid, n_ov - ov0, exp_q.size());
    end
  endtask

  task automatic test_parity();
    int pe0;
    m_ready = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h07) begin
      errors++;
      $display("FAIL parity_good got valid=%b data=%h expected 1 07", m_valid, m_data);
    end
    @(posedge clk);
    #1;
    pe0 = n_pe;
    if (!PAR_ON) exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    checks++;
    if (parity_err !== PAR_ON || m_valid !== !PAR_ON) begin
      errors++;
      $display("FAIL parity_bad got pe=%b valid=%b expected %b %b", parity_err, m_valid, PAR_ON, !PAR_ON);
    end
    @(posedge clk);
    #1;
    checks++;
    if (n_pe - pe0 !== int'(PAR_ON)) begin
      errors++;
      $display("FAIL parity_once got=%0d expected=%0d", n_pe - pe0, int'(PAR_ON));
    end
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_reset_midframe();
    test_back_to_back();
    test_parity();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_pending got=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Receiver stage directly downstream of the data transmitter's PISO serial output. Detects a start bit on the serial line and shifts in DATA_W data bits, MSB first. Checks the stop bit and presents the recovered word on a valid/ready parallel interface. Synchronous link: one bit per clk, no oversampling; the transmitter and receiver share clk.

Parameters:
DATA_W, 8, data bits per frame (2..32)
MSB_FIRST, 1, 1 = first data bit received lands in m_data[DATA_W-1]; 0 = lands in m_data[0]

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
serial_in  in  1  serial line; idle level 0
m_data  out  DATA_W  received word, stable while m_valid=1
m_valid  out  1  word available
m_ready  in  1  consumer accepts word when m_valid&&m_ready
busy  out  1  high while a frame is in progress (state != IDLE)
frame_err  out  1  one-cycle pulse: bad stop bit
parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 without SFR_PARITY_EN)
overrun  out  1  one-cycle pulse: good frame dropped because holding register is full

Behaviour:
- Reset value of all outputs is 0, including m_data. State is IDLE, bit counter is 0, and the shift register is 0.
- Frame format: start bit (1), DATA_W data bits, optional parity bit, stop bit (0).
- IDLE: serial_in=1 sampled -> DATA with cnt=0. serial_in=0 -> remain in IDLE.
- DATA: shift serial_in in on each cycle, cnt++. When cnt==DATA_W-1 the cycle shifts the last bit, then go to PARITY if enabled, else STOP.
- STOP: sample serial_in, then always return to IDLE.
  - Stop bit=1 -> frame_err pulse the next cycle; word discarded.
  - Stop bit=0 and holding register empty, or being drained this same cycle -> load m_data and set m_valid the next cycle.
  - Stop bit=0 and holding register full with no handshake this cycle -> overrun pulse; new word dropped; old m_data kept.
- Latency: m_valid rises the cycle after the stop bit is sampled. A frame occupies DATA_W+2 cycles, or DATA_W+3 with parity.
- Back-to-back frames: a start bit in the cycle immediately after the stop bit is accepted with no gap.
- Handshake: m_valid stays high and m_data stays stable until m_valid&&m_ready. m_valid drops the cycle after acceptance unless a new word loads in that same cycle, in which case m_valid stays high with the new data.
- Error pulses are mutually exclusive per frame. Priority: frame_err > parity_err > overrun.
- Asserting rst mid-frame aborts the frame immediately. No error pulse is produced and the holding register is cleared.
- busy is asserted in DATA/PARITY/STOP and deasserted in IDLE.

Optional Feature:
SFR_PARITY_EN
- Defined: a PARITY state follows DATA. It samples one bit; even parity is required over the data bits plus the parity bit.
- On mismatch with a good stop bit, parity_err pulses and the word is discarded. A bad stop bit reports frame_err instead.
- Undefined: there is no PARITY state and no parity logic; parity_err is tied 0 and the frame is DATA_W+2 cycles long.

Decomposition:
- Package sfr_pkg holds:
  - the state enum sfr_state_t {IDLE, DATA, PARITY, STOP};
  - a function computing the frame length from DATA_W and the parity setting;
  - the idle-level and stop-level constants.
- Sub-module sfr_hold_reg: a one-entry valid/ready holding register with load, drain and full status. It is reusable elsewhere in the codebase.
- FSM, shifter and counter stay in serial_frame_rx.

Test Plan:
- rst pulse, then line idle 0 for 5 cycles -> all outputs 0, busy=0, no m_valid.
- Serial 1,1,1,0,0,1,1,0,0,0 (start, 0xCC MSB-first, stop), m_ready=1 -> m_valid high for exactly 1 cycle, 1 cycle after the stop bit, with m_data=8'hCC.
- Two back-to-back frames 0xA5 then 0x3C with m_ready=0 -> first word held at 8'hA5; overrun pulses once after the second stop bit. Then set m_ready=1 -> 8'hA5 accepted; m_valid drops.
- Frame 0x5A with stop bit 1 -> frame_err pulses once, m_valid stays 0, FSM returns to IDLE. Next valid frame 0x01 -> received correctly.
- rst asserted for one cycle after 4 data bits -> busy=0 immediately, no error pulse. A following frame 0xFF -> m_data=8'hFF.
- With SFR_PARITY_EN: frame 0x07 with parity bit 1 -> m_data=8'h07. Same frame with parity bit 0 -> parity_err pulses once and m_valid stays 0.
